dm_arbiter: RTL

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 101 ++++++++++
 1 files changed

// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Each access runs IDLE/RESP -> ACCESS -> RESP, with its payload latched at the grant edge.
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m0_pc,
  input  logic [31:0] m1_pc,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t      state, state_next;
  logic        lat_we, lat_err, lat_id, last_grant;
  logic [31:0] lat_addr, lat_wdata, lat_pc;
  logic        arb_en, win_id, sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata, sel_pc;

  // A lone requester always wins; under contention the one not granted last wins.
  always_comb begin
    win_id = m1_req;
    if (m0_req && m1_req) win_id = ~last_grant;
    sel_we    = win_id ? m1_we    : m0_we;
    sel_addr  = win_id ? m1_addr  : m0_addr;
    sel_wdata = win_id ? m1_wdata : m0_wdata;
    sel_pc    = win_id ? m1_pc    : m0_pc;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
    arb_en    = (state != ACCESS) && (m0_req || m1_req);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, RESP: state_next = arb_en ? ACCESS : IDLE;
      ACCESS:     state_next = RESP;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Request registers double as the held dm_* bus values between accesses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_id     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_pc     <= '0;
      last_grant <= 1'b1;
    end else if (arb_en) begin
      lat_we     <= sel_we;
      lat_err    <= sel_err;
      lat_id     <= win_id;
      lat_addr   <= sel_addr;
      lat_wdata  <= sel_wdata;
      lat_pc     <= sel_pc;
      last_grant <= win_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                           m_rdata <= '0;
    else if (state == ACCESS && !lat_we)  m_rdata <= dm_rdata;
  end

  assign m0_gnt    = (state == ACCESS) && !lat_id;
  assign m1_gnt    = (state == ACCESS) &&  lat_id;
  assign m0_rvalid = (state == RESP)   && !lat_id;
  assign m1_rvalid = (state == RESP)   &&  lat_id;
  assign m_err     = (state == RESP)   &&  lat_err;
  assign dm_we     = (state == ACCESS) &&  lat_we && !lat_err;
  assign dm_addr   = lat_addr;
  assign dm_wdata  = lat_wdata;
  assign dm_pc     = lat_pc;

endmodule
